// File: rtl/axi_slave_mem_pkg.sv
// axi_slave_mem_pkg
// Shared definitions for the simplified AXI-style bus: field widths, bit
// positions of the packed channel fields, response codes and the state
// encodings of the slave's read and write FSMs. Both bus ends import this
// so the field packing stays identical on each side.
package axi_slave_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 4;
  localparam int DATA_W = 8;

  // ARIN = {ARADDR, ARLEN, ARID}
  localparam int AR_W        = ADDR_W + LEN_W + ID_W;
  localparam int AR_ID_LSB   = 0;
  localparam int AR_LEN_LSB  = ID_W;
  localparam int AR_ADDR_LSB = ID_W + LEN_W;

  // AWIN = {AWADDR, AWID}
  localparam int AW_W        = ADDR_W + ID_W;
  localparam int AW_ID_LSB   = 0;
  localparam int AW_ADDR_LSB = ID_W;

  // ROUT = {RDATA, RRESP}
  localparam int ROUT_W     = DATA_W + 1;
  localparam int R_RESP_BIT = 0;
  localparam int R_DATA_LSB = 1;

  // BRESP = {BID, BERR}
  localparam int BRESP_W   = ID_W + 1;
  localparam int B_ERR_BIT = 0;
  localparam int B_ID_LSB  = 1;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  // True when a bus address maps onto an implemented memory byte.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int depth);
    return int'(addr) < depth;
  endfunction

endpackage

// File: rtl/axi_slave_mem_mem.sv
// slave_mem
// DEPTH x 8 byte array: one synchronous write port, one asynchronous read
// port. Out-of-range gating is done by the caller.
//   clk    in  clock
//   we     in  write enable (write on rising edge)
//   waddr  in  write index
//   wdata  in  write byte
//   raddr  in  read index
//   rdata  out read byte (combinational)
module slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; contents persist across rst, and a reset
  // loop over every entry would stop it mapping onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read: a same-cycle write lands at the edge, so a read
  // sampled at that edge still sees the old byte (read-first).
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem
// Responder end of the simplified AXI-style bus. Services read bursts
// (AR/R) and write bursts (AW/W/B) from an internal byte memory. The read
// and write FSMs are independent and may run concurrently.
//   clk, rst          clock; asynchronous active-high reset
//   ARVALID/ARIN      read request {addr, len, id}; ARREADY accept pulse
//   RVALID/ROUT/RLAST read beat {data, resp}; RREADY master accept
//   AWVALID/AWIN      write request {addr, id}; AWREADY accept pulse
//   WVALID/WDATA/WLAST write beat; WREADY slave accepts beats
//   BVALID/BRESP      write response {id, err}; BREADY master accept
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ARVALID,
  input  logic [AR_W-1:0]    ARIN,
  output logic               ARREADY,
  output logic               RVALID,
  input  logic               RREADY,
  output logic [ROUT_W-1:0]  ROUT,
  output logic               RLAST,
  input  logic               AWVALID,
  input  logic [AW_W-1:0]    AWIN,
  output logic               AWREADY,
  input  logic               WVALID,
  input  logic [DATA_W-1:0]  WDATA,
  input  logic               WLAST,
  output logic               WREADY,
  output logic               BVALID,
  input  logic               BREADY,
  output logic [BRESP_W-1:0] BRESP
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;    // beats remaining after the presented one
  w_state_t          w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [ID_W-1:0]   w_id;
  logic              w_err;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [ROUT_W-1:0] rd_beat;
  logic              w_in_range;
  logic              mem_we;

  // The R channel carries no id, so the read id has no consumer.
  logic unused_ar_id;
  assign unused_ar_id = ^ARIN[AR_ID_LSB +: ID_W];

  // While a beat is presented, the memory is already looking at the next
  // address so ROUT can reload on the transfer edge.
  assign rd_addr = (r_state == R_DATA) ? r_addr + ADDR_W'(1) : r_addr;

  // NOTE: always_comb gives every output a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    rd_beat = {DATA_W'(0), RESP_ERR};
    if (in_range(rd_addr, DEPTH)) rd_beat = {mem_rdata, RESP_OK};
  end

  assign w_in_range = in_range(w_addr, DEPTH);
  assign mem_we     = (w_state == W_DATA) && WVALID && w_in_range;

  slave_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_addr[IDX_W-1:0]),
    .wdata (WDATA),
    .raddr (rd_addr[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      ROUT    <= '0;
      RLAST   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ARVALID) begin
          r_addr  <= ARIN[AR_ADDR_LSB +: ADDR_W];
          r_cnt   <= ARIN[AR_LEN_LSB +: LEN_W];
          ARREADY <= 1'b1;
          r_state <= R_ADDR;
        end
        R_ADDR: begin
          ARREADY <= 1'b0;
          RVALID  <= 1'b1;
          ROUT    <= rd_beat;
          RLAST   <= (r_cnt == '0);
          r_state <= R_DATA;
        end
        R_DATA: if (RREADY) begin
          if (RLAST) begin
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            ROUT    <= '0;
            r_state <= R_IDLE;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt - LEN_W'(1);
            ROUT   <= rd_beat;
            RLAST  <= (r_cnt == LEN_W'(1));
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_id    <= '0;
      w_err   <= 1'b0;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (AWVALID) begin
          w_addr  <= AWIN[AW_ADDR_LSB +: ADDR_W];
          w_id    <= AWIN[AW_ID_LSB +: ID_W];
          w_err   <= 1'b0;
          AWREADY <= 1'b1;
          w_state <= W_ADDR;
        end
        W_ADDR: begin
          AWREADY <= 1'b0;
          WREADY  <= 1'b1;
          w_state <= W_DATA;
        end
        W_DATA: if (WVALID) begin
          w_addr <= w_addr + ADDR_W'(1);
          if (!w_in_range) w_err <= 1'b1;
          if (WLAST) begin
            // Fold in the final beat's range check, which w_err has not seen yet.
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= {w_id, w_err | ~w_in_range};
            w_state <= W_RESP;
          end
        end
        W_RESP: if (BREADY) begin
          BVALID  <= 1'b0;
          BRESP   <= '0;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem
// Drives identical bus traffic into two slaves (DEPTH 256 and DEPTH 128)
// and compares both against a byte-array model of the bus semantics.
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY;
  logic [15:0] ARIN;
  logic [11:0] AWIN;
  logic [7:0]  WDATA;

  logic       arready [2];
  logic       rvalid  [2];
  logic       rlast   [2];
  logic       awready [2];
  logic       wready  [2];
  logic       bvalid  [2];
  logic [8:0] rout    [2];
  logic [4:0] bresp   [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: every byte ever written through the bus, indexed by bus address.
  logic [7:0] mem_m [256];
  logic [7:0] wq [$];

  always #5 clk = ~clk;

  axi_slave_mem #(.DEPTH(256)) u_dut256 (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARIN(ARIN), .ARREADY(arready[0]),
    .RVALID(rvalid[0]), .RREADY(RREADY), .ROUT(rout[0]), .RLAST(rlast[0]),
    .AWVALID(AWVALID), .AWIN(AWIN), .AWREADY(awready[0]),
    .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(wready[0]),
    .BVALID(bvalid[0]), .BREADY(BREADY), .BRESP(bresp[0])
  );

  axi_slave_mem #(.DEPTH(128)) u_dut128 (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARIN(ARIN), .ARREADY(arready[1]),
    .RVALID(rvalid[1]), .RREADY(RREADY), .ROUT(rout[1]), .RLAST(rlast[1]),
    .AWVALID(AWVALID), .AWIN(AWIN), .AWREADY(awready[1]),
    .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(wready[1]),
    .BVALID(bvalid[1]), .BREADY(BREADY), .BRESP(bresp[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 128;
  endfunction

  // Expected {data, resp} for a read of bus address a on instance k.
  function automatic logic [8:0] exp_beat(input int k, input logic [7:0] a);
    if (int'(a) < dep(k)) return {mem_m[a], 1'b0};
    return 9'h001;
  endfunction

  function automatic logic [19:0] all_outs(input int k);
    return {arready[k], rvalid[k], rout[k], rlast[k],
            awready[k], wready[k], bvalid[k], bresp[k]};
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[depth %0d]: observed %0h expected %0h", tag, dep(k), obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [3:0] id,
                          input logic [7:0] data [$], input int bstall, input bit rnd);
    logic [1:0] err;
    logic [7:0] a;
    err = '0;
    AWIN = {addr, id}; AWVALID = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) check("aw_accept", k, {awready[k], wready[k]}, 2'b10);
    AWVALID = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) check("w_ready", k, {awready[k], wready[k]}, 2'b01);
    for (int b = 0; b < data.size(); b++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        WVALID = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) check("w_gap", k, {wready[k], bvalid[k]}, 2'b10);
      end
      a = addr + 8'(b);
      WVALID = 1'b1; WDATA = data[b]; WLAST = (b == data.size() - 1);
      mem_m[a] = data[b];
      for (int k = 0; k < 2; k++) if (int'(a) >= dep(k)) err[k] = 1'b1;
      tick();
      if (b != data.size() - 1)
        for (int k = 0; k < 2; k++) check("w_mid", k, {wready[k], bvalid[k]}, 2'b10);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    for (int k = 0; k < 2; k++)
      check("b_resp", k, {wready[k], bvalid[k], bresp[k]}, {2'b01, id, err[k]});
    for (int s = 0; s < bstall; s++) begin
      tick();
      for (int k = 0; k < 2; k++)
        check("b_hold", k, {bvalid[k], bresp[k]}, {1'b1, id, err[k]});
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    for (int k = 0; k < 2; k++) check("b_done", k, bvalid[k], 1'b0);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                         input int stall_beat, input int stall_cycles, input bit rnd);
    logic [7:0] a;
    int stalls;
    ARIN = {addr, len, id}; ARVALID = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) check("ar_accept", k, {arready[k], rvalid[k]}, 2'b10);
    ARVALID = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) check("ar_pulse_end", k, arready[k], 1'b0);
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 8'(b);
      stalls = (b == stall_beat) ? stall_cycles :
               (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int s = 0; s <= stalls; s++) begin
        RREADY = (s == stalls);
        for (int k = 0; k < 2; k++)
          check($sformatf("r_beat%0d", b), k, {rvalid[k], rout[k], rlast[k]},
                {1'b1, exp_beat(k, a), b == int'(len)});
        tick();
      end
    end
    RREADY = 1'b0;
    for (int k = 0; k < 2; k++) check("r_end", k, {rvalid[k], rout[k], rlast[k]}, 11'h0);
  endtask

  initial begin
    rst = 1'b1;
    ARVALID = 0; RREADY = 0; AWVALID = 0; WVALID = 0; WLAST = 0; BREADY = 0;
    ARIN = '0; AWIN = '0; WDATA = '0;
    tick();
    for (int k = 0; k < 2; k++) check("reset_outs", k, all_outs(k), 20'h0);
    rst = 1'b0;
    tick();

    // Fill the whole address space with random bytes via 16-beat bursts;
    // the upper half reports BERR on the DEPTH=128 slave.
    for (int base = 0; base < 256; base += 16) begin
      wq = {};
      for (int i = 0; i < 16; i++) wq.push_back(8'($urandom));
      do_write(8'(base), 4'($urandom), wq, 0, 1'b0);
    end

    // Single read.
    wq = {8'hA5};
    do_write(8'h10, 4'h1, wq, 0, 1'b0);
    do_read(8'h10, 4'd0, 4'd3, -1, 0, 1'b0);

    // Four-beat write then read back; response held two cycles.
    wq = {8'h11, 8'h22, 8'h33, 8'h44};
    do_write(8'h20, 4'h6, wq, 2, 1'b0);
    do_read(8'h20, 4'd3, 4'd2, -1, 0, 1'b0);

    // Back-pressure: beat 2 of 3 stalled two cycles.
    do_read(8'h20, 4'd2, 4'd4, 1, 2, 1'b0);

    // Straddling the DEPTH=128 boundary.
    wq = {8'hC3, 8'h3C};
    do_write(8'h7F, 4'h9, wq, 0, 1'b0);
    do_read(8'h7F, 4'd1, 4'd9, -1, 0, 1'b0);

    // Address wrap from 0xFF to 0x00.
    wq = {8'hE1, 8'h1E};
    do_write(8'hFF, 4'h2, wq, 0, 1'b0);
    do_read(8'hFF, 4'd1, 4'd5, -1, 0, 1'b0);

    // Read-first: the read's first beat loads at the same edge the write
    // beat lands at the same address.
    wq = {8'h01};
    do_write(8'h30, 4'h0, wq, 0, 1'b0);
    AWIN = {8'h30, 4'h2}; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0; ARIN = {8'h30, 4'h0, 4'h1}; ARVALID = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) check("rf_accept", k, {arready[k], wready[k]}, 2'b11);
    ARVALID = 1'b0; WDATA = 8'h77; WVALID = 1'b1; WLAST = 1'b1;
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("rf_old_data", k, {rvalid[k], rout[k], rlast[k]}, {1'b1, 8'h01, 1'b0, 1'b1});
      check("rf_bresp", k, {bvalid[k], bresp[k]}, {1'b1, 4'h2, 1'b0});
    end
    mem_m[8'h30] = 8'h77;
    RREADY = 1'b1; BREADY = 1'b1;
    tick();
    RREADY = 1'b0; BREADY = 1'b0;
    for (int k = 0; k < 2; k++) check("rf_done", k, {rvalid[k], bvalid[k]}, 2'b00);
    do_read(8'h30, 4'd0, 4'd1, -1, 0, 1'b0);

    // Asynchronous reset in the middle of a read and a write burst.
    AWIN = {8'h40, 4'h3}; AWVALID = 1'b1;
    ARIN = {8'h20, 4'd7, 4'h8}; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; ARVALID = 1'b0;
    tick();
    WVALID = 1'b1; WDATA = 8'h5A; RREADY = 1'b1;
    tick();
    WDATA = 8'h6B;
    tick();
    WVALID = 1'b0; RREADY = 1'b0;
    mem_m[8'h40] = 8'h5A;
    mem_m[8'h41] = 8'h6B;
    for (int k = 0; k < 2; k++) check("mid_burst", k, {rvalid[k], wready[k]}, 2'b11);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) check("async_reset", k, all_outs(k), 20'h0);
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) check("post_reset_idle", k, all_outs(k), 20'h0);
    do_read(8'h40, 4'd1, 4'd7, -1, 0, 1'b0);
    do_read(8'h1E, 4'd5, 4'd0, -1, 0, 1'b0);

    // Random bursts with random gaps and stalls.
    for (int it = 0; it < 16; it++) begin
      wq = {};
      for (int i = 0; i <= int'($urandom_range(0, 15)); i++) wq.push_back(8'($urandom));
      do_write(8'($urandom), 4'($urandom), wq, int'($urandom_range(0, 2)), 1'b1);
      do_read(8'($urandom), 4'($urandom), 4'($urandom), -1, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
